lal_tag_count_seq: RTL and testbench

- Registered counterpart to the combinational lal next-state and compare logic.
- Owns the 9-bit count register and the 4-bit tag register, and accepts key lookups over a valid/ready handshake.
- Returns one match event per accepted key: hit flag plus count snapshot, buffered in a small FIFO.
- Sits between the lookup initiator and the event consumer.

---
 rtl/lal_pkg.sv | 27 ++
 rtl/lal_evt_fifo.sv | 64 ++++++
 rtl/lal_tag_count_seq.sv | 93 +++++++++
 tb/tb_lal_tag_count_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/lal_pkg.sv
// Shared definitions for the lal tag/count block.
//   LAL_CNT_W    : default width of the count register
//   LAL_TAG_W    : default width of the tag register and lookup key
//   LAL_INV_MASK : key bits inverted before the tag compare
//   lal_evt_t    : one match event {hit, count snapshot}
//   lal_match()  : tag compare with inversion mask
package lal_pkg;

  localparam int LAL_CNT_W = 9;
  localparam int LAL_TAG_W = 4;
  localparam logic [LAL_TAG_W-1:0] LAL_INV_MASK = 4'b1000;

  typedef struct packed {
    logic                 hit;
    logic [LAL_CNT_W-1:0] cnt;
  } lal_evt_t;

  // A set mask bit means that key bit must differ from the tag bit.
  function automatic logic lal_match(
    input logic [LAL_TAG_W-1:0] key,
    input logic [LAL_TAG_W-1:0] tag,
    input logic [LAL_TAG_W-1:0] mask
  );
    return ((key ^ mask) == tag);
  endfunction

endpackage

// File: rtl/lal_evt_fifo.sv
// Synchronous FIFO of lal_evt_t match events.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data at the tail (ignored when full)
//   push_data  : event to store
//   pop        : remove the head (ignored when empty)
//   head       : current head event, all zeros when empty
//   full/empty : occupancy flags, derived from registered state only
//   fill       : occupancy 0..DEPTH
module lal_evt_fifo
  import lal_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  lal_evt_t               push_data,
  input  logic                   pop,
  output lal_evt_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;

  lal_evt_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [FW-1:0]   fill_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (fill_q == FW'(DEPTH));
  assign empty   = (fill_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign fill    = fill_q;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage is not reset; the empty gate on head hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   fill_q <= fill_q + FW'(1);
        2'b01:   fill_q <= fill_q - FW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule

// File: rtl/lal_tag_count_seq.sv
// Registered lal block: count register, tag register and key lookups.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid must stay asserted with stable payload until accepted,
// and ready never depends combinationally on the same-cycle valid.
//   load/load_val/hold/cnt_en : count control, priority load > hold > cnt_en
//   cnt_q, wrap               : count value, one-cycle wrap-by-increment pulse
//   tag_wr/tag_in             : tag register write
//   key_vld/key/key_rdy       : lookup request (key_rdy = FIFO not full)
//   evt_vld/evt_rdy           : match event stream out of the FIFO
//   evt_hit/evt_cnt           : head event, zeros when empty
//   evt_cnt_fill              : FIFO occupancy
module lal_tag_count_seq
  import lal_pkg::*;
#(
  parameter int                CNT_W    = LAL_CNT_W,
  parameter int                TAG_W    = LAL_TAG_W,
  parameter logic [TAG_W-1:0]  INV_MASK = LAL_INV_MASK,
  parameter int                DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [CNT_W-1:0]       load_val,
  input  logic                   hold,
  input  logic                   cnt_en,
  output logic [CNT_W-1:0]       cnt_q,
  output logic                   wrap,
  input  logic                   tag_wr,
  input  logic [TAG_W-1:0]       tag_in,
  input  logic                   key_vld,
  input  logic [TAG_W-1:0]       key,
  output logic                   key_rdy,
  output logic                   evt_vld,
  input  logic                   evt_rdy,
  output logic                   evt_hit,
  output logic [CNT_W-1:0]       evt_cnt,
  output logic [$clog2(DEPTH):0] evt_cnt_fill
);

  logic [TAG_W-1:0] tag_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             key_acc;
  lal_evt_t         new_evt;
  lal_evt_t         head_evt;

  // Count register: load > hold > cnt_en > keep.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      cnt_q <= load_val;
      wrap  <= 1'b0;
    end else if (hold) begin
      wrap  <= 1'b0;
    end else if (cnt_en) begin
      cnt_q <= cnt_q + CNT_W'(1);
      wrap  <= &cnt_q;
    end else begin
      wrap  <= 1'b0;
    end
  end

  // Tag register; a same-cycle lookup sees the old value.
  always_ff @(posedge clk) begin
    if (rst)         tag_q <= '0;
    else if (tag_wr) tag_q <= tag_in;
  end

  assign key_rdy     = !fifo_full;
  assign key_acc     = key_vld && key_rdy;
  // Snapshot is the count before this cycle's update.
  assign new_evt.hit = lal_match(key, tag_q, INV_MASK);
  assign new_evt.cnt = cnt_q;

  lal_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (key_acc),
    .push_data (new_evt),
    .pop       (evt_rdy),
    .head      (head_evt),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (evt_cnt_fill)
  );

  assign evt_vld = !fifo_empty;
  assign evt_hit = head_evt.hit;
  assign evt_cnt = head_evt.cnt;

endmodule

// File: tb/tb_lal_tag_count_seq.sv
module tb_lal_tag_count_seq;

  localparam int CNT_W = 9;
  localparam int TAG_W = 4;
  localparam int DEPTH = 2;
  localparam int FW    = $clog2(DEPTH) + 1;
  localparam logic [TAG_W-1:0] INV_MASK = 4'b1000;
  localparam int CNT_MOD = 1 << CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic [CNT_W-1:0] load_val = '0;
  logic             hold = 1'b0;
  logic             cnt_en = 1'b0;
  logic [CNT_W-1:0] cnt_q;
  logic             wrap;
  logic             tag_wr = 1'b0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             key_vld = 1'b0;
  logic [TAG_W-1:0] key = '0;
  logic             key_rdy;
  logic             evt_vld;
  logic             evt_rdy = 1'b0;
  logic             evt_hit;
  logic [CNT_W-1:0] evt_cnt;
  logic [FW-1:0]    evt_cnt_fill;

  lal_tag_count_seq #(
    .CNT_W(CNT_W), .TAG_W(TAG_W), .INV_MASK(INV_MASK), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .hold(hold),
    .cnt_en(cnt_en), .cnt_q(cnt_q), .wrap(wrap), .tag_wr(tag_wr),
    .tag_in(tag_in), .key_vld(key_vld), .key(key), .key_rdy(key_rdy),
    .evt_vld(evt_vld), .evt_rdy(evt_rdy), .evt_hit(evt_hit),
    .evt_cnt(evt_cnt), .evt_cnt_fill(evt_cnt_fill)
  );

  // ---------------- reference model / scoreboard ----------------
  int               m_cnt;
  logic             m_wrap;
  logic [TAG_W-1:0] m_tag;
  logic [CNT_W:0]   exp_q[$];   // {hit, cnt snapshot}, head at index 0
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  // One clock: advance the model from the inputs present before the edge,
  // then compare every output 1 ns after the edge.
  task automatic step();
    bit             push;
    bit             pop;
    logic           hit;
    logic [CNT_W:0] head;
    push = key_vld && (exp_q.size() < DEPTH);
    pop  = evt_rdy && (exp_q.size() > 0);
    hit  = ((key ^ INV_MASK) == m_tag);
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_wrap = 1'b0; m_tag = '0; exp_q.delete();
    end else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back({hit, CNT_W'(m_cnt)});
      if (load) begin
        m_cnt = int'(load_val); m_wrap = 1'b0;
      end else if (hold) begin
        m_wrap = 1'b0;
      end else if (cnt_en) begin
        m_wrap = (m_cnt == CNT_MOD - 1);
        m_cnt  = (m_cnt + 1) % CNT_MOD;
      end else begin
        m_wrap = 1'b0;
      end
      if (tag_wr) m_tag = tag_in;
    end
    #1;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("cnt_q",   32'(cnt_q),        32'(m_cnt));
    chk("wrap",    32'(wrap),         32'(m_wrap));
    chk("key_rdy", 32'(key_rdy),      32'(exp_q.size() < DEPTH));
    chk("evt_vld", 32'(evt_vld),      32'(exp_q.size() > 0));
    chk("fill",    32'(evt_cnt_fill), 32'(exp_q.size()));
    chk("evt_hit", 32'(evt_hit),      32'(head[CNT_W]));
    chk("evt_cnt", 32'(evt_cnt),      32'(head[CNT_W-1:0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    bit acc;
    m_cnt = 0; m_wrap = 1'b0; m_tag = '0;

    // reset then idle
    rst = 1'b1; step();
    rst = 1'b0; idle(3);
    chk("reset_cnt_literal", 32'(cnt_q), 32'd0);

    // load 510 then increment through the wrap
    load_val = 9'd510; load = 1'b1; step();
    load = 1'b0; cnt_en = 1'b1; idle(3);
    chk("after_wrap_literal", 32'(cnt_q), 32'd1);
    cnt_en = 1'b0; step();

    // hold beats cnt_en, load beats hold
    load_val = 9'd5; load = 1'b1; step();
    load = 1'b0; hold = 1'b1; cnt_en = 1'b1; idle(4);
    chk("hold_literal", 32'(cnt_q), 32'd5);
    load = 1'b1; load_val = 9'd9; step();
    chk("load_over_hold_literal", 32'(cnt_q), 32'd9);
    load = 1'b0; hold = 1'b0; cnt_en = 1'b0;

    // tag compare with inversion mask, same-cycle tag write uses old tag
    tag_wr = 1'b1; tag_in = 4'b0101; step();
    tag_wr = 1'b0; evt_rdy = 1'b1;
    key_vld = 1'b1; key = 4'b1101; step();
    chk("hit_literal", 32'(evt_hit), 32'd1);
    key = 4'b0101; step();
    chk("miss_literal", 32'(evt_hit), 32'd0);
    key = 4'b1101; tag_wr = 1'b1; tag_in = 4'b1111; step();
    chk("old_tag_hit_literal", 32'(evt_hit), 32'd1);
    tag_wr = 1'b0; key_vld = 1'b0; idle(2);

    // back-pressure: third key held while FIFO full
    evt_rdy = 1'b0; load_val = 9'd3; load = 1'b1; step();
    load = 1'b0; cnt_en = 1'b1; key_vld = 1'b1; key = 4'b0010; idle(3);
    chk("full_key_rdy_literal", 32'(key_rdy), 32'd0);
    chk("full_head_cnt_literal", 32'(evt_cnt), 32'd3);
    cnt_en = 1'b0; evt_rdy = 1'b1; step();
    chk("pop_order_literal", 32'(evt_cnt), 32'd4);
    step();
    key_vld = 1'b0; idle(3);

    // reset mid-stream with a key pending
    evt_rdy = 1'b0; key_vld = 1'b1; key = 4'b1111; idle(2);
    rst = 1'b1; step();
    chk("rst_fill_literal", 32'(evt_cnt_fill), 32'd0);
    rst = 1'b0; key_vld = 1'b0; step();

    // random traffic; a refused key is held stable until accepted
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = ($urandom_range(0, 3) == 0) ? CNT_W'(CNT_MOD - 2) : CNT_W'($urandom);
      hold     = ($urandom_range(0, 7) == 0);
      cnt_en   = ($urandom_range(0, 3) != 0);
      tag_wr   = ($urandom_range(0, 7) == 0);
      tag_in   = TAG_W'($urandom);
      evt_rdy  = ($urandom_range(0, 2) != 0);
      acc = key_vld && (exp_q.size() < DEPTH);
      if (!key_vld || acc || rst) begin
        key_vld = ($urandom_range(0, 1) == 1);
        key     = TAG_W'($urandom);
      end
      step();
    end

    rst = 1'b0; key_vld = 1'b0; evt_rdy = 1'b1; idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
